// File: rtl/gpio_db_pkg.sv
// Shared widths and types for the GPIO input synchroniser/debounce block.
// Optional glitch statistics are enabled with GPIO_DB_GLITCH_STAT_EN.
package gpio_db_pkg;

    localparam int DEF_NPIN     = 32;
    localparam int DEF_DB_CNT_W = 4;
    localparam int DEF_PRESC_W  = 16;
    localparam int SYNC_STAGES  = 2;

    typedef logic [DEF_DB_CNT_W-1:0] db_cnt_t;

endpackage

// File: rtl/gpio_in_debounce_bit.sv
// One pin: synchroniser, stability counter, filtered level and change pulse.
// Glitch sticky status exists only when GPIO_DB_GLITCH_STAT_EN is defined.
module gpio_db_bit
    import gpio_db_pkg::*;
#(
    parameter int DB_CNT_W = DEF_DB_CNT_W
) (
    input  logic                mclk,
    input  logic                h_reset,
    input  logic                raw,
    input  logic                db_en,
    input  logic                db_tick,
    input  logic [DB_CNT_W-1:0] db_thresh,
    output logic                filt,
    output logic                chg
`ifdef GPIO_DB_GLITCH_STAT_EN
    ,
    input  logic                glitch_clr,
    output logic                glitch_sts
`endif
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q;
    logic [DB_CNT_W-1:0]    cnt;
    logic [DB_CNT_W-1:0]    cnt_next;
    logic                   filt_next;
    logic [DB_CNT_W:0]      cnt_inc;
    logic [DB_CNT_W:0]      thr_eff;

    assign sync_q  = sync_r[SYNC_STAGES-1];
    assign cnt_inc = {1'b0, cnt} + (DB_CNT_W+1)'(1);
    // A zero threshold behaves like a single stable tick.
    assign thr_eff = (db_thresh == '0) ? (DB_CNT_W+1)'(1)
                                       : {1'b0, db_thresh};

    always_ff @(posedge mclk or posedge h_reset) begin
        if (h_reset) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
        end
    end

    always_comb begin
        filt_next = filt;
        cnt_next  = cnt;
        if (!db_en) begin
            filt_next = sync_q;
            cnt_next  = '0;
        end else if (sync_q == filt) begin
            cnt_next = '0;
        end else if (db_tick) begin
            if (cnt_inc >= thr_eff) begin
                filt_next = sync_q;
                cnt_next  = '0;
            end else begin
                cnt_next = cnt_inc[DB_CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge mclk or posedge h_reset) begin
        if (h_reset) begin
            filt <= 1'b0;
            chg  <= 1'b0;
            cnt  <= '0;
        end else begin
            filt <= filt_next;
            chg  <= filt_next ^ filt;
            cnt  <= cnt_next;
        end
    end

`ifdef GPIO_DB_GLITCH_STAT_EN
    logic glitch_set;

    // Input fell back to the filtered level after counting had started.
    assign glitch_set = db_en && (sync_q == filt) && (cnt != '0);

    always_ff @(posedge mclk or posedge h_reset) begin
        if (h_reset) begin
            glitch_sts <= 1'b0;
        end else begin
            glitch_sts <= glitch_set | (glitch_sts & ~glitch_clr);
        end
    end
`endif

endmodule

// File: rtl/gpio_in_debounce.sv
// GPIO pad input conditioning: shared prescaler plus NPIN per-pin filters.
// Define GPIO_DB_GLITCH_STAT_EN to add cfg_glitch_clr/gpio_glitch_sts.
module gpio_in_debounce
    import gpio_db_pkg::*;
#(
    parameter int NPIN     = DEF_NPIN,
    parameter int DB_CNT_W = DEF_DB_CNT_W,
    parameter int PRESC_W  = DEF_PRESC_W
) (
    input  logic                mclk,
    input  logic                h_reset,
    input  logic [NPIN-1:0]     pad_gpio_in_raw,
    input  logic [NPIN-1:0]     cfg_db_en,
    input  logic [PRESC_W-1:0]  cfg_db_presc,
    input  logic [DB_CNT_W-1:0] cfg_db_thresh,
    output logic [NPIN-1:0]     gpio_in_filt,
    output logic [NPIN-1:0]     gpio_in_chg
`ifdef GPIO_DB_GLITCH_STAT_EN
    ,
    input  logic [NPIN-1:0]     cfg_glitch_clr,
    output logic [NPIN-1:0]     gpio_glitch_sts
`endif
);

    logic [PRESC_W-1:0] presc_cnt;
    logic               db_tick;

    // >= rather than == so a lowered period wraps at once.
    assign db_tick = (presc_cnt >= cfg_db_presc);

    always_ff @(posedge mclk or posedge h_reset) begin
        if (h_reset) begin
            presc_cnt <= '0;
        end else if (db_tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + PRESC_W'(1);
        end
    end

    for (genvar i = 0; i < NPIN; i++) begin : g_pin
        gpio_db_bit #(
            .DB_CNT_W(DB_CNT_W)
        ) u_bit (
            .mclk      (mclk),
            .h_reset   (h_reset),
            .raw       (pad_gpio_in_raw[i]),
            .db_en     (cfg_db_en[i]),
            .db_tick   (db_tick),
            .db_thresh (cfg_db_thresh),
            .filt      (gpio_in_filt[i]),
            .chg       (gpio_in_chg[i])
`ifdef GPIO_DB_GLITCH_STAT_EN
            ,
            .glitch_clr(cfg_glitch_clr[i]),
            .glitch_sts(gpio_glitch_sts[i])
`endif
        );
    end

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed scoreboard bench for gpio_in_debounce.
// Glitch status checks are built when GPIO_DB_GLITCH_STAT_EN is defined.
module tb_gpio_in_debounce;

    localparam int NPIN = 32;
    localparam int CW   = 4;
    localparam int PW   = 16;
    localparam logic [31:0] P5 = 32'h20;
    localparam logic [31:0] ALL = 32'hFFFF_FFFF;

    logic            mclk;
    logic            h_reset;
    logic [NPIN-1:0] raw;
    logic [NPIN-1:0] en;
    logic [PW-1:0]   presc;
    logic [CW-1:0]   thresh;
    logic [NPIN-1:0] filt;
    logic [NPIN-1:0] chg;
`ifdef GPIO_DB_GLITCH_STAT_EN
    logic [NPIN-1:0] gclr;
    logic [NPIN-1:0] gsts;
`endif

    gpio_in_debounce #(
        .NPIN(NPIN),
        .DB_CNT_W(CW),
        .PRESC_W(PW)
    ) dut (
        .mclk           (mclk),
        .h_reset        (h_reset),
        .pad_gpio_in_raw(raw),
        .cfg_db_en      (en),
        .cfg_db_presc   (presc),
        .cfg_db_thresh  (thresh),
        .gpio_in_filt   (filt),
        .gpio_in_chg    (chg)
`ifdef GPIO_DB_GLITCH_STAT_EN
        ,
        .cfg_glitch_clr (gclr),
        .gpio_glitch_sts(gsts)
`endif
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    typedef struct {
        string       tag;
        logic [31:0] f;
        logic [31:0] c;
        logic [31:0] m;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic cmp(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] f,
                        input logic [31:0] c, input logic [31:0] m);
        exp_t e;
        e.tag = tag;
        e.f   = f;
        e.c   = c;
        e.m   = m;
        sbq.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_empty observed=0 expected=1");
        end else begin
            e = sbq.pop_front();
            cmp({e.tag, "_filt"}, filt & e.m, e.f & e.m);
            cmp({e.tag, "_chg"}, chg & e.m, e.c & e.m);
        end
    endtask

    task automatic tk(input int n);
        repeat (n) @(negedge mclk);
    endtask

    initial begin
        logic [31:0] acc;
        logic [31:0] cur;
        logic [31:0] prev;

        h_reset = 1'b1;
        raw     = '0;
        en      = '0;
        presc   = '0;
        thresh  = '0;
`ifdef GPIO_DB_GLITCH_STAT_EN
        gclr    = '0;
`endif
        tk(2);
        push("reset", 32'h0, 32'h0, ALL);
        pop_check();
        h_reset = 1'b0;
        tk(3);

        // Bypass path: three edges raw -> filt, single chg pulse.
        raw = 32'h1;
        push("byp_e2", 32'h0, 32'h0, 32'h1);
        tk(2);
        pop_check();
        push("byp_e3", 32'h1, 32'h1, 32'h1);
        tk(1);
        pop_check();
        push("byp_e4", 32'h1, 32'h0, 32'h1);
        tk(1);
        pop_check();
        raw = '0;
        tk(4);

        // Debounce pass: prescaler starts from 0, ticks at edges 10..40.
        thresh = 4'd4;
        en     = P5;
        presc  = 16'd9;
        raw    = P5;
        push("db_e39", 32'h0, 32'h0, 32'h21);
        tk(39);
        pop_check();
        push("db_e40", P5, P5, 32'h21);
        tk(1);
        pop_check();
        push("db_e41", P5, 32'h0, 32'h21);
        tk(1);
        pop_check();

        // Drop pin 5 through bypass, then re-enable filtering from 0.
        en    = '0;
        raw   = '0;
        presc = '0;
        tk(4);
        en    = P5;
        presc = 16'd9;
        raw   = P5;
        acc   = '0;
        for (int k = 0; k < 25; k++) begin
            tk(1);
            acc |= (filt | chg) & P5;
        end
        raw = '0;
        for (int k = 0; k < 35; k++) begin
            tk(1);
            acc |= (filt | chg) & P5;
        end
        cmp("glitch_reject", acc, 32'h0);
`ifdef GPIO_DB_GLITCH_STAT_EN
        cmp("glitch_sts_set", gsts, P5);
        tk(3);
        cmp("glitch_sts_sticky", gsts, P5);
        gclr = P5;
        tk(1);
        gclr = '0;
        cmp("glitch_sts_clr", gsts, 32'h0);
`endif

        // presc=0, thresh=0: filtered pin tracks like bypass.
        presc  = '0;
        thresh = '0;
        raw    = P5;
        push("b0_rise_e2", 32'h0, 32'h0, P5);
        tk(2);
        pop_check();
        push("b0_rise_e3", P5, P5, P5);
        tk(1);
        pop_check();
        push("b0_rise_e4", P5, 32'h0, P5);
        tk(1);
        pop_check();
        raw = '0;
        push("b0_fall_e2", P5, 32'h0, P5);
        tk(2);
        pop_check();
        push("b0_fall_e3", 32'h0, P5, P5);
        tk(1);
        pop_check();

        // Prescaler at 500 of 1000; lowering to 3 must tick next edge.
        thresh = 4'd1;
        presc  = 16'd1000;
        raw    = P5;
        push("presc_hold", 32'h0, 32'h0, P5);
        tk(500);
        pop_check();
        presc = 16'd3;
        push("presc_lower", P5, P5, P5);
        tk(1);
        pop_check();

        // Counter reaches 3 toward falling, then async reset.
        thresh = 4'd4;
        presc  = '0;
        raw    = '0;
        push("rst_pre", P5, 32'h0, P5);
        tk(5);
        pop_check();
        h_reset = 1'b1;
        #1;
        push("rst_async", 32'h0, 32'h0, ALL);
        pop_check();
        raw = P5;
        tk(1);
        h_reset = 1'b0;
        push("rst_e5", 32'h0, 32'h0, P5);
        tk(5);
        pop_check();
        push("rst_e6", P5, P5, P5);
        tk(1);
        pop_check();

        // Walking ones: bypass pins land on edge 3, filtered on edge 4.
        raw    = '0;
        en     = 32'h5555_5555;
        thresh = 4'd2;
        presc  = '0;
        tk(6);
        push("walk_init", 32'h0, 32'h0, ALL);
        pop_check();
        prev = '0;
        for (int i = 0; i < NPIN; i++) begin
            cur = 32'h1 << i;
            raw = cur;
            push($sformatf("walk%0d_e3", i),
                 (cur & ~en) | (prev & en), (cur ^ prev) & ~en, ALL);
            tk(3);
            pop_check();
            push($sformatf("walk%0d_e4", i), cur, (cur ^ prev) & en, ALL);
            tk(1);
            pop_check();
            tk(2);
            prev = cur;
        end

        if (sbq.size() != 0) begin
            total++;
            bad++;
            $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpio_in_debounce.md
Name: gpio_in_debounce

Overview:
- Input conditioning stage directly upstream of the GPIO controller.
- Takes raw asynchronous pad inputs, synchronises them into the mclk domain, and optionally applies a per-pin debounce filter.
- gpio_in_filt drives the GPIO controller's pad_gpio_in, so edge-interrupt logic only sees clean, stable levels.
- Debounce timebase comes from a shared prescaler tick; the required stable-tick count is common to all pins.

Parameters:
- NPIN, 32, number of GPIO pins.
- DB_CNT_W, 4, width of per-pin stability counter and of cfg_db_thresh.
- PRESC_W, 16, width of prescaler counter and of cfg_db_presc.

Ports:
- mclk  input  1  system clock.
- h_reset  input  1  asynchronous, active-high reset.
- pad_gpio_in_raw  input  NPIN  raw pad levels, asynchronous to mclk.
- cfg_db_en  input  NPIN  per-pin debounce enable (1 = filtered, 0 = sync only).
- cfg_db_presc  input  PRESC_W  tick period = cfg_db_presc+1 mclk cycles.
- cfg_db_thresh  input  DB_CNT_W  consecutive stable ticks required; 0 is treated as 1.
- gpio_in_filt  output  NPIN  conditioned level, feeds the GPIO controller's pad_gpio_in.
- gpio_in_chg  output  NPIN  one-cycle pulse when the corresponding gpio_in_filt bit changes.

Behaviour:
- Reset: all sync flops, gpio_in_filt, gpio_in_chg, prescaler and stability counters go to 0. Reset is asynchronous assert; deassertion is clocked by mclk.
- Sync: 2-flop synchroniser per pin; sync_q is the second stage.
- Prescaler:
  - Counts up each cycle; db_tick=1 for one cycle when cnt >= cfg_db_presc, and cnt then returns to 0.
  - cfg_db_presc=0 gives a tick every cycle.
  - If presc is lowered below the current count mid-run, the next cycle ticks and wraps (no 2^PRESC_W stall).
- Pin with cfg_db_en=0:
  - gpio_in_filt <= sync_q every cycle; stability counter held at 0.
  - Latency raw->filt is 3 mclk edges.
- Pin with cfg_db_en=1:
  - sync_q == filt: counter cleared to 0 that cycle, tick or not.
  - sync_q != filt and db_tick, with counter+1 >= max(thresh,1): filt <= sync_q and counter <= 0.
  - sync_q != filt and db_tick, below threshold: counter increments. The counter never exceeds thresh, so there is no wrap.
  - sync_q != filt, no tick: counter holds.
- cfg_db_en 1->0: counter cleared; filt follows sync_q from the next cycle.
- cfg_db_en 0->1: filtering starts from the current filt value with counter 0.
- gpio_in_chg[i] = registered (filt_next != filt); it is high in the same cycle the new filt value is visible.
- Simultaneous tick and input reversal: the equality check wins and the counter clears.
- Threshold change mid-count: the new value is compared on the next tick; a counter already >= the new threshold qualifies at that tick.

Optional Feature:
- Macro GPIO_DB_GLITCH_STAT_EN.
- With the macro, extra ports are present:
  - cfg_glitch_clr  input  NPIN
  - gpio_glitch_sts  output  NPIN
- gpio_glitch_sts[i] is sticky. It is set when a debounced pin's counter is non-zero and is cleared because sync_q returned to filt (a rejected glitch).
- A cfg_glitch_clr[i] pulse clears the bit; set wins over clear in the same cycle. Reset value is 0.
- Without the macro, these ports and their logic are absent.

Decomposition:
- Package gpio_db_pkg holds:
  - the default widths (NPIN, DB_CNT_W, PRESC_W);
  - typedef db_cnt_t = logic [DB_CNT_W-1:0];
  - localparam SYNC_STAGES=2.
- Sub-module gpio_db_bit holds one pin's synchroniser, stability counter, filt/chg registers and, under the macro, the glitch sticky bit.
- The top instantiates the single prescaler and a generate loop of NPIN gpio_db_bit instances.

Test Plan:
- Bypass latency: cfg_db_en=0, raw[0] 0->1 -> gpio_in_filt[0]=1 on the 3rd mclk edge, with gpio_in_chg[0] pulsing for exactly 1 cycle.
- Debounce pass: en[5]=1, presc=9, thresh=4; raw[5] held high -> filt[5] rises after the 4th tick (~40 cycles plus 2 sync cycles), with one chg pulse.
- Glitch reject: same config, raw[5] high for 25 cycles then low -> filt[5] stays 0, no chg pulse. With the macro, gpio_glitch_sts[5]=1 until a cfg_glitch_clr[5] pulse.
- Boundary: presc=0, thresh=0 -> filt follows sync_q one cycle later (treated as thresh 1). Lowering presc from 1000 to 3 while the prescaler is at 500 -> tick on the next cycle.
- Reset mid-operation: assert h_reset while counter=3 and filt=1 -> filt, chg and counter go to 0 immediately (asynchronous); after release, a high raw input needs the full threshold again.
- All pins: walking-ones pattern on 32 pins with mixed cfg_db_en -> each filt bit updates independently, with no cross-pin interaction.
